// File: rtl/pc_gen.sv
// Fetch-stage program counter with valid/ready handshake.
// Redirects on exception, ERET and branch with MIPS delay-slot semantics.
module pc_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              pc_misaligned
);

    localparam logic [ADDR_W-1:0] INC  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t            state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              fire;

    assign fire          = pc_valid & pc_ready;
    assign pc_misaligned = (pc & MASK) != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            pc_valid    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (state == BOOT) begin
            state    <= RUN;
            pc_valid <= 1'b1;
        end else if (exc_valid) begin
            pc         <= exc_target;
            pend_valid <= 1'b0;
        end else if (eret_valid) begin
            pc         <= epc;
            pend_valid <= 1'b0;
        end else if (fire) begin
            // the accepted pc is the delay slot when a branch resolves now
            if (branch_valid) begin
                pc <= branch_target;
            end else if (pend_valid) begin
                pc <= pend_target;
            end else begin
                pc <= pc + INC;
            end
            pend_valid <= 1'b0;
        end else if (branch_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_target;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: every accepted fetch is compared
// against a hand-computed expected {misaligned, pc} queue.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_target = '0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_misaligned;

    int checks = 0;
    int failures = 0;
    logic [32:0] sb[$];

    pc_gen dut (
        .clk(clk),
        .rst(rst),
        .pc_ready(pc_ready),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .exc_valid(exc_valid),
        .exc_target(exc_target),
        .eret_valid(eret_valid),
        .epc(epc),
        .pc(pc),
        .pc_valid(pc_valid),
        .pc_misaligned(pc_misaligned)
    );

    always #5 clk = ~clk;

    // monitor: pops one expectation per accepted fetch
    always @(negedge clk) begin
        if (rst && pc_valid && pc_ready) begin
            logic [32:0] exp;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL fetch: got pc=%h mis=%b, required nothing queued",
                         pc, pc_misaligned);
            end else begin
                exp = sb.pop_front();
                if ({pc_misaligned, pc} !== exp) begin
                    failures++;
                    $display("FAIL fetch: got pc=%h mis=%b, required pc=%h mis=%b",
                             pc, pc_misaligned, exp[31:0], exp[32]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic drive(input bit rdy, input bit push, input logic [32:0] exp,
                         input bit br = 0, input logic [31:0] bt = '0,
                         input bit ex = 0, input logic [31:0] et = '0,
                         input bit er = 0, input logic [31:0] ep = '0);
        if (push) sb.push_back(exp);
        pc_ready      = rdy;
        branch_valid  = br;
        branch_target = bt;
        exc_valid     = ex;
        exc_target    = et;
        eret_valid    = er;
        epc           = ep;
        @(posedge clk);
        #1;
        branch_valid = 1'b0;
        exc_valid    = 1'b0;
        eret_valid   = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'hBFC00000);
        chk("rst_valid", {31'b0, pc_valid}, 32'd0);
        rst = 1'b1;
        chk("boot_valid", {31'b0, pc_valid}, 32'd0);
        // BOOT cycle: redirect pulse must be ignored
        drive(1, 0, '0, 1, 32'h1111_0000, 1, 32'h0000_1234);
        drive(1, 1, {1'b0, 32'hBFC00000});
        drive(1, 1, {1'b0, 32'hBFC00004});
        drive(1, 1, {1'b0, 32'hBFC00008});
        drive(1, 1, {1'b0, 32'hBFC0000C});
        repeat (3) drive(0, 0, '0);
        chk("hold_pc", pc, 32'hBFC00010);
        chk("hold_valid", {31'b0, pc_valid}, 32'd1);
        drive(1, 1, {1'b0, 32'hBFC00010});
        drive(1, 1, {1'b0, 32'hBFC00014});
        drive(1, 1, {1'b0, 32'hBFC00018});
        drive(1, 1, {1'b0, 32'hBFC0001C});
        // delay slot accepted with branch
        drive(1, 1, {1'b0, 32'hBFC00020}, 1, 32'h80001000);
        drive(1, 1, {1'b0, 32'h80001000});
        // branch while delay slot stalled
        drive(0, 0, '0, 1, 32'h80002000);
        drive(0, 0, '0);
        drive(1, 1, {1'b0, 32'h80001004});
        drive(1, 1, {1'b0, 32'h80002000});
        // pending branch (overwritten) killed by exception
        drive(0, 0, '0, 1, 32'h80003000);
        drive(0, 0, '0, 1, 32'h80004000);
        drive(1, 1, {1'b0, 32'h80002004}, 0, '0, 1, 32'hBFC00380);
        drive(1, 1, {1'b0, 32'hBFC00380});
        // exc and eret together: exc wins
        drive(1, 1, {1'b0, 32'hBFC00384}, 0, '0, 1, 32'hBFC00400, 1, 32'h80005000);
        chk("exc_eret", pc, 32'hBFC00400);
        // eret without fire
        drive(0, 0, '0, 0, '0, 0, '0, 1, 32'hFFFFFFF8);
        drive(1, 1, {1'b0, 32'hFFFFFFF8});
        drive(1, 1, {1'b0, 32'hFFFFFFFC});
        drive(1, 1, {1'b0, 32'h00000000}, 1, 32'h80000002);
        drive(1, 1, {1'b1, 32'h80000002});
        drive(1, 1, {1'b1, 32'h80000006});
        // pending overwritten then taken
        drive(0, 0, '0, 1, 32'h90000000);
        drive(0, 0, '0, 1, 32'h90001000);
        drive(1, 1, {1'b1, 32'h8000000A});
        drive(1, 1, {1'b0, 32'h90001000});
        chk("after_pend", pc, 32'h90001004);
        // reset mid-run with a pending branch
        drive(0, 0, '0, 1, 32'hA0000000);
        rst = 1'b0;
        #2;
        chk("mid_rst_pc", pc, 32'hBFC00000);
        chk("mid_rst_valid", {31'b0, pc_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 0, '0);
        drive(1, 1, {1'b0, 32'hBFC00000});
        drive(1, 1, {1'b0, 32'hBFC00004});
        drive(0, 0, '0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
